// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the alu_ctrl sequencer: opcodes, instruction layout,
// FSM encoding and default sizes.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int NREG_DEF    = 8;
  localparam int INSTR_W     = 16;
  localparam int REG_AW      = 3;

  // Instruction field positions (LSB of each field)
  localparam int OP_LSB      = 14;
  localparam int IMM_SEL_BIT = 13;
  localparam int RD_LSB      = 10;
  localparam int RS1_LSB     = 7;
  localparam int RS2_LSB     = 4;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 7;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    SHL = 2'b10,
    SHR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } state_e;

  typedef struct packed {
    alu_op_e           op;
    logic              imm_sel;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [IMM_W-1:0]  imm;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t d;
    d.op      = alu_op_e'(w[OP_LSB +: 2]);
    d.imm_sel = w[IMM_SEL_BIT];
    d.rd      = w[RD_LSB +: REG_AW];
    d.rs1     = w[RS1_LSB +: REG_AW];
    d.rs2     = w[RS2_LSB +: REG_AW];
    d.imm     = w[IMM_LSB +: IMM_W];
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// Register file: two operand read ports, one debug read port, one write port.
// Entry 0 always reads zero and is never written.
module alu_ctrl_regfile
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] daddr,
  output logic [DATA_W-1:0] ddata,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NREG];

  function automatic logic hit(input logic [REG_AW-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && hit(waddr)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = hit(raddr_a) ? mem[raddr_a] : '0;
  assign rdata_b = hit(raddr_b) ? mem[raddr_b] : '0;
  assign ddata   = hit(daddr)   ? mem[daddr]   : '0;

endmodule

// File: rtl/alu_ctrl.sv
// Three-phase instruction sequencer (IDLE -> EXEC -> WB) driving an external
// combinational ALU and writing results back into a small register file.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state, nstate;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] res_q;
  instr_t            d;
  logic [DATA_W-1:0] rs1_val, rs2_val, opb;
  logic              accept;

  assign d      = decode(instr_q);
  assign accept = instr_valid && instr_ready;
  assign opb    = d.imm_sel ? {{(DATA_W-IMM_W){1'b0}}, d.imm} : rs2_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      instr_q <= '0;
      res_q   <= '0;
    end else begin
      state <= nstate;
      if (accept)           instr_q <= instr;
      if (state == S_EXEC)  res_q   <= alu_result;
    end
  end

  always_comb begin
    nstate      = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    alu_a       = '0;
    alu_b       = '0;
    alu_opcode  = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) nstate = S_EXEC;
      end
      S_EXEC: begin
        alu_a      = rs1_val;
        alu_b      = opb;
        alu_opcode = d.op;
        nstate     = S_WB;
      end
      S_WB: begin
        wb_valid = 1'b1;
        wb_addr  = d.rd;
        wb_data  = res_q;
        nstate   = S_IDLE;
      end
      // The spare encoding can only appear through an upset; recover to IDLE.
      default: nstate = S_IDLE;
    endcase
  end

  alu_ctrl_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (d.rs1),
    .rdata_a (rs1_val),
    .raddr_b (d.rs2),
    .rdata_b (rs2_val),
    .daddr   (dbg_addr),
    .ddata   (dbg_data),
    .we      (wb_valid),
    .waddr   (d.rd),
    .wdata   (res_q)
  );

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl: directed instructions push expected write-backs,
// a negedge monitor pops and compares each wb_valid pulse including its timing.
module tb_alu_ctrl;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [1:0]        alu_opcode;
  logic              wb_valid;
  logic [2:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              busy;
  logic [2:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  alu_ctrl #(.DATA_W(DATA_W), .NREG(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .busy        (busy),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    case (alu_opcode)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a << alu_b[4:0];
      default: alu_result = alu_a >> alu_b[4:0];
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]        a;
    logic [DATA_W-1:0] d;
    int                acc_edge;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   last_acc = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: write-back pulses must match the scoreboard in order and timing.
  exp_t me;
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) chk("ready_low_when_busy", instr_ready, 0);
      else      chk("alu_zero_when_idle", (alu_a != 0) || (alu_b != 0) || (alu_opcode != 0), 0);
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", 1, 0);
        end else begin
          me = exp_q.pop_front();
          chk("wb_addr", wb_addr, me.a);
          chk("wb_data", wb_data, me.d);
          // wb is visible in the cycle following the edge after the accepting edge
          chk("wb_latency", cyc, me.acc_edge + 1);
        end
      end
    end
  end

  function automatic logic [15:0] mk_imm(input logic [1:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [6:0] imm);
    return {op, 1'b1, rd, rs1, imm};
  endfunction

  function automatic logic [15:0] mk_reg(input logic [1:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, 1'b0, rd, rs1, rs2, 4'b0};
  endfunction

  task automatic issue(input logic [15:0] w, input bit expect_wb, input logic [2:0] a,
                       input logic [DATA_W-1:0] dv, input bit hold, input bit gap_chk);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = w;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    e.a = a; e.d = dv; e.acc_edge = cyc + 1;
    if (expect_wb) exp_q.push_back(e);
    if (gap_chk) chk("accept_gap", e.acc_edge - last_acc, 3);
    last_acc = e.acc_edge;
    @(posedge clk);
    if (!hold) begin
      #1;
      instr_valid = 1'b0;
      instr       = 16'hFFFF;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_dbg(input logic [2:0] a, input logic [DATA_W-1:0] exp, input string nm);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, exp);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_alu", {alu_opcode, alu_a | alu_b}, 0);
    chk_dbg(3'd1, 0, "rst_r1");
    rst    = 1'b0;
    mon_en = 1'b1;

    // r1 = r0 + 5
    issue(mk_imm(2'b00, 3'd1, 3'd0, 7'd5), 1, 3'd1, 32'd5, 0, 0);
    wait_idle();
    chk_dbg(3'd1, 32'd5, "dbg_r1");

    // r2 = 10, r3 = r1 - r2
    issue(mk_imm(2'b00, 3'd2, 3'd0, 7'd10), 1, 3'd2, 32'd10, 0, 0);
    issue(mk_reg(2'b01, 3'd3, 3'd1, 3'd2), 1, 3'd3, 32'hFFFF_FFFB, 0, 0);
    wait_idle();
    chk_dbg(3'd3, 32'hFFFF_FFFB, "dbg_r3");

    // r4 = r1 << 3, r5 = r4 >> 2
    issue(mk_imm(2'b10, 3'd4, 3'd1, 7'd3), 1, 3'd4, 32'd40, 0, 0);
    issue(mk_imm(2'b11, 3'd5, 3'd4, 7'd2), 1, 3'd5, 32'd10, 0, 0);
    wait_idle();
    chk_dbg(3'd4, 32'd40, "dbg_r4");
    chk_dbg(3'd5, 32'd10, "dbg_r5");

    // instr_valid held high across a dependent burst
    issue(mk_imm(2'b00, 3'd6, 3'd0, 7'd100), 1, 3'd6, 32'd100, 1, 0);
    issue(mk_imm(2'b00, 3'd7, 3'd6, 7'd27), 1, 3'd7, 32'd127, 1, 1);
    issue(mk_reg(2'b01, 3'd1, 3'd7, 3'd6), 1, 3'd1, 32'd27, 0, 1);
    wait_idle();
    chk_dbg(3'd1, 32'd27, "dbg_r1_burst");

    // Max immediate, and addition wrapping to zero
    issue(mk_imm(2'b00, 3'd2, 3'd0, 7'd127), 1, 3'd2, 32'd127, 0, 0);
    issue(mk_imm(2'b00, 3'd3, 3'd3, 7'd5), 1, 3'd3, 32'd0, 0, 0);
    wait_idle();
    chk_dbg(3'd2, 32'd127, "dbg_r2_imm127");
    chk_dbg(3'd3, 32'd0, "dbg_r3_wrap");

    // Write to r0 still pulses wb but r0 stays zero
    issue(mk_imm(2'b00, 3'd0, 3'd0, 7'd7), 1, 3'd0, 32'd7, 0, 0);
    wait_idle();
    chk_dbg(3'd0, 32'd0, "dbg_r0");

    // Reset during EXEC aborts r6 = 9 with no write-back
    chk_dbg(3'd6, 32'd100, "dbg_r6_before_abort");
    issue(mk_imm(2'b00, 3'd6, 3'd0, 7'd9), 0, 3'd6, 32'd9, 0, 0);
    @(negedge clk);
    chk("abort_in_exec", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", instr_ready, 1);
    chk("abort_busy", busy, 0);
    chk_dbg(3'd6, 32'd0, "abort_r6");
    rst = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, datapath width; NREG, default 8, register-file entries (r0 reads zero).
REQ-002 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  controller can accept an instruction.
- instr  input  16  instruction word.
- alu_a  output  DATA_W  operand A to the external combinational ALU.
- alu_b  output  DATA_W  operand B to the ALU.
- alu_opcode  output  2  ALU op: 00 add, 01 sub, 10 shl, 11 shr.
- alu_result  input  DATA_W  ALU result, combinational from alu_a/alu_b/alu_opcode.
- wb_valid  output  1  one-cycle write-back strobe.
- wb_addr  output  3  destination register.
- wb_data  output  DATA_W  written value.
- busy  output  1  high while not IDLE.
- dbg_addr  input  3  debug read address.
- dbg_data  output  DATA_W  combinational register-file read, 0 for r0.

Function
REQ-003 SHALL decode instr as: [15:14] op, [13] imm_sel, [12:10] rd, [9:7] rs1; imm_sel=0 -> [6:4] rs2; imm_sel=1 -> B = zero-extended [6:0].
REQ-004 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; no other states; unreachable encodings return to IDLE.
REQ-005 SHALL assert instr_ready only in IDLE; transfer occurs on instr_valid && instr_ready at a rising edge, latching instr and moving to EXEC.
REQ-006 In EXEC SHALL drive alu_a = R[rs1], alu_b = R[rs2] or immediate, alu_opcode = op, and register alu_result into a result register; moves to WB.
REQ-007 In WB SHALL assert wb_valid for exactly one cycle with wb_addr = rd, wb_data = result register, write R[rd] at that edge unless rd = 0, then return to IDLE.
REQ-008 Latency: handshake at edge T -> wb_valid high in cycle T+2 -> instr_ready high again in cycle T+3; max throughput one instruction per 3 cycles.
REQ-009 SHALL hold alu_a, alu_b, alu_opcode at 0 outside EXEC.
REQ-010 Writes to rd = 0 SHALL still pulse wb_valid but leave r0 reading 0.
REQ-011 Arithmetic SHALL wrap modulo 2^DATA_W; shift amount is alu_b[4:0] (ALU-defined); immediate 0..127.
REQ-012 Read-after-write: an instruction accepted after a WB SHALL see the written value (write completes before next EXEC).
REQ-013 instr_valid changes while not IDLE SHALL be ignored; instr content is don't-care when instr_valid=0.
REQ-014 dbg_data SHALL reflect a write in the cycle after its WB edge.

Reset
REQ-015 On rst at a rising edge SHALL enter IDLE, clear all registers R1..R(NREG-1) and the result register to 0, and drive instr_ready=1, busy=0, wb_valid=0, wb_addr=0, wb_data=0, ALU outputs 0.
REQ-016 rst asserted in EXEC or WB SHALL abort the instruction with no register write and no wb_valid pulse; rst takes priority over a simultaneous handshake.

Structure
REQ-017 A shared package SHALL hold opcode constants (ADD, SUB, SHL, SHR), instruction field bit positions, FSM state encoding and DATA_W/NREG defaults.
REQ-018 The register file SHALL be a sub-module alu_ctrl_regfile: two combinational read ports plus debug read, one synchronous write port, r0 forced to zero; the ALU stays external.

Verification
REQ-019 Bench SHALL cover:
- Reset then imm add r1 = r0 + 5 (op00, imm_sel1, rd1, imm 5) -> wb_valid at T+2, wb_addr 1, wb_data 5; dbg_addr 1 -> 5.
- r2 = 10 by imm, then sub r3 = r1 - r2 (op01) -> wb_data 0xFFFFFFFB.
- r1=5, shl r4 = r1 << 3 (op10 imm 3) -> 40; shr r5 = r4 >> 2 (op11 imm 2) -> 10.
- instr_valid held high continuously -> instr_ready low in EXEC/WB, exactly one accept per 3 cycles, no instruction lost or duplicated.
- Write rd=0 with imm 7 -> wb_valid pulses, dbg_addr 0 -> 0.
- rst asserted in EXEC of add r6 = imm 9 -> no wb_valid, dbg_addr 6 -> 0, instr_ready=1 next cycle.
